// File: rtl/exp_bcd_out_if.sv
// Handshake bundle between the exponent search stage, the BCD converter and the readout logic.
interface exp_bcd_out_if;
  logic        done;
  logic [15:0] g;
  logic        bcd_ack;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd;
  logic [2:0]  ndigits;
  logic        overrun;

  modport master (
    output done, g, bcd_ack,
    input  busy, bcd_valid, bcd, ndigits, overrun
  );

  modport slave (
    input  done, g, bcd_ack,
    output busy, bcd_valid, bcd, ndigits, overrun
  );
endinterface

// File: rtl/exp_bcd_out.sv
// Captures the exponent result on a rising done, converts it to five BCD digits
// with a one-bit-per-cycle double-dabble engine and holds it under valid/ack.
module exp_bcd_out (
  input logic          clk,
  input logic          rst,
  exp_bcd_out_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q;
  logic        done_q;
  logic [15:0] sr_q;
  logic [19:0] scr_q;
  logic [4:0]  cnt_q;
  logic [19:0] bcd_q;
  logic [2:0]  nd_q;
  logic        busy_q;
  logic        valid_q;
  logic        ovr_q;

  logic        cap;
  logic [19:0] scr_d;
  logic [15:0] sr_d;

  // Pre-shift correction: any digit of 5 or more gets +3 so the shift carries into the next digit.
  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [2:0] sig_digits(input logic [19:0] d);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 1; i < 5; i++) begin
      if (d[4*i +: 4] != 4'd0) n = 3'(i + 1);
    end
    return n;
  endfunction

  assign cap = bus.done & ~done_q;

  always_comb begin
    {scr_d, sr_d} = {add3(scr_q), sr_q} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      nd_q    <= 3'd1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= bus.done;
      // A new result arriving while one is in flight or held is dropped.
      if (cap && (state_q != IDLE)) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cap) begin
            sr_q    <= bus.g;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            bcd_q   <= scr_d;
            nd_q    <= sig_digits(scr_d);
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (bus.bcd_ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.ndigits   = nd_q;
  assign bus.overrun   = ovr_q;

endmodule
